ysyx_22041412_clint_regs: RTL
=============================

# ysyx_22041412_clint_regs

Memory-mapped register front end of the CLINT. Decodes core load/store requests into the CLINT window and owns the 64-bit `mtime` counter, `mtimecmp` and `msip` registers. Produces the level timer interrupt (`mtip`) and software interrupt (`msip`) that feed the CLINT interrupt aggregation and, from there, the CSR `mip` logic. Uses a single-outstanding valid/ready request/response port driven by the LSU.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `BASE`, 32'h0200_0000, CLINT window base address
- `TICK_DIV`, 1, core clocks per `mtime` increment (≥1)

Ports (one clock; reset asynchronous, active-low):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-low reset
- `mtime_en`  in  1  count enable for `mtime`
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when valid & ready
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  64  write data
- `req_wstrb`  in  8  byte write strobes
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed when valid & ready
- `rsp_rdata`  out  64  read data (0 on writes/errors)
- `rsp_err`  out  1  access error
- `mtip`  out  1  timer interrupt pending, level
- `msip`  out  1  software interrupt pending, level

## Operation
- Register map (offset from `BASE`): 0x0000 `msip` (bit 0 only; other bits read 0, ignore writes); 0x4000 `mtimecmp` (64-bit); 0xBFF8 `mtime` (64-bit).
- Accesses are 64-bit; `req_addr[2:0]` ≠ 0 or any unmapped offset → `rsp_err`=1, `rsp_rdata`=0, no state change.
- Writes: byte-lane merge under `req_wstrb`; `wstrb`=0 is a legal no-op write with `rsp_err`=0.
- FSM: IDLE (`req_ready`=1) → on accept, perform access, go RESP; RESP (`rsp_valid`=1, `req_ready`=0) → on `rsp_ready`, go IDLE. Response data is held stable until consumed.
- Prescaler counts 0..TICK_DIV-1 while `mtime_en`=1, holds when 0; `mtime` increments by 1 on prescaler wrap. With TICK_DIV=1, `mtime` increments every enabled cycle.
- `mtime` wraps 0xFFFF_FFFF_FFFF_FFFF → 0 with no flag.
- Write to `mtime` in a tick cycle: write wins (merged value loaded, no increment); prescaler unaffected.
- Read of `mtime` returns the pre-increment value of the accept cycle.
- `mtip` = registered (`mtime` ≥ `mtimecmp`), unsigned 64-bit compare, evaluated every cycle on current register values.
- `msip` output = `msip` register bit 0.

## Timing
- Reset values: `mtime`=0, `mtimecmp`=all ones, `msip`=0, `mtip`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `req_ready`=1, prescaler=0, FSM=IDLE.
- Request accepted in cycle N → `rsp_valid` in N+1; write takes effect at the N→N+1 edge.
- Back-to-back throughput: one request per 2 cycles minimum (RESP consumed in N+1, next accept in N+2).
- `mtip` rises/falls one cycle after the `mtime`/`mtimecmp` register update that changes the compare.
- Reset asserted mid-transaction: response is dropped, all state returns to reset values immediately.

## Structure
- Shared package `ysyx_22041412_clint_pkg`: offsets `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`; FSM state encodings `CLINT_IDLE`, `CLINT_RESP`.
- One sub-module: `ysyx_22041412_clint_tick` (prescaler + 64-bit counter with load port, outputs count value).
- Decode, byte-merge, compare and FSM stay in the top.

## Test plan
- Reset, TICK_DIV=1, `mtime_en`=1 for 10 cycles, then read 0xBFF8 → `rsp_rdata`=10 (±accept-cycle alignment as specified), `rsp_err`=0, `mtip`=0.
- Write `mtimecmp`=20, run until `mtime`=20 → `mtip`=1 on the following cycle; write `mtimecmp`=all ones → `mtip`=0 one cycle later.
- Write `mtime`=0xFFFF_FFFF_FFFF_FFFE with wstrb=0xFF, enable 2 ticks → reads back 0; write coinciding with tick loads the written value exactly.
- Write 0x0000_0003 to 0x0000 → `msip`=1, read returns 1; write 0 → `msip`=0.
- Read 0x0004 (misaligned) and 0x1000 (unmapped) → `rsp_err`=1, `rsp_rdata`=0, no register change; hold `rsp_ready`=0 three cycles → `rsp_valid`/data stable, `req_ready`=0.
- TICK_DIV=4, `mtime_en` toggled off for 3 cycles mid-count → `mtime` increments once per 4 enabled cycles; assert `rst` during RESP → `rsp_valid`=0 and all registers at reset values.

Source files
------------

// File: rtl/ysyx_22041412_clint_pkg.sv
// Shared definitions for the CLINT register front end.
//   - Register offsets within the CLINT window.
//   - Request/response FSM state encoding.
//   - Byte-lane merge helper used for strobed 64-bit writes.
package ysyx_22041412_clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic {
    CLINT_IDLE = 1'b0,
    CLINT_RESP = 1'b1
  } clint_state_e;

  // Replace each byte of old_val whose strobe bit is set with the matching byte of new_val.
  function automatic logic [63:0] clint_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22041412_clint_tick.sv
// mtime time base: prescaler plus 64-bit free-running counter with a load port.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             count enable; prescaler holds while low
//   load, load_val synchronous load of the counter (takes priority over a tick)
//   count          current counter value
module ysyx_22041412_clint_tick
  import ysyx_22041412_clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [63:0] load_val,
  output logic [63:0] count
);

  // Keep at least one prescaler bit so TICK_DIV=1 still elaborates cleanly.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [63:0]   count_q, count_d;
  logic          tick;

  assign tick = en && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (en) pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // A load in a tick cycle wins and swallows the increment; the prescaler keeps running.
  always_comb begin
    count_d = count_q;
    if (load)      count_d = load_val;
    else if (tick) count_d = count_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      count_q <= '0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ysyx_22041412_clint_regs.sv
// CLINT register front end: decodes LSU requests into the CLINT window and owns
// msip, mtimecmp and mtime. Drives the level mtip/msip interrupt outputs.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   mtime_en                       mtime count enable
//   req_valid/req_ready            request handshake (single outstanding)
//   req_we, req_addr, req_wdata,
//   req_wstrb                      request payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             response payload (held until consumed)
//   mtip, msip                     timer / software interrupt pending
//
// FSM states:
//   state      | meaning
//   CLINT_IDLE | ready for a request; access performed in the accept cycle
//   CLINT_RESP | response held on rsp_* until rsp_ready
module ysyx_22041412_clint_regs
  import ysyx_22041412_clint_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] BASE     = 32'h0200_0000,
  parameter int                TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mtime_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mtip,
  output logic              msip
);

  clint_state_e      state_q, state_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic [63:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              msip_q, msip_d;
  logic              mtip_q, mtip_d;

  logic [63:0]       mtime_val;
  logic [63:0]       mtime_load_val;
  logic              mtime_load;

  logic [ADDR_W-1:0] req_off;
  logic              aligned;
  logic              sel_msip, sel_mtimecmp, sel_mtime, hit;
  logic              accept, do_write;
  logic [63:0]       rd_data;

  // Address decode; an address below BASE wraps to a huge offset and misses.
  assign req_off      = req_addr - BASE;
  assign aligned      = (req_addr[2:0] == 3'b000);
  assign sel_msip     = aligned && (req_off == ADDR_W'(CLINT_MSIP_OFF));
  assign sel_mtimecmp = aligned && (req_off == ADDR_W'(CLINT_MTIMECMP_OFF));
  assign sel_mtime    = aligned && (req_off == ADDR_W'(CLINT_MTIME_OFF));
  assign hit          = sel_msip || sel_mtimecmp || sel_mtime;

  assign accept   = req_valid && (state_q == CLINT_IDLE);
  // A zero-strobe write changes nothing; keeping it off the mtime load port
  // stops it from swallowing a tick.
  assign do_write = accept && hit && req_we && (req_wstrb != 8'h00);

  assign mtime_load     = do_write && sel_mtime;
  assign mtime_load_val = clint_merge(mtime_val, req_wdata, req_wstrb);

  ysyx_22041412_clint_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst),
    .en       (mtime_en),
    .load     (mtime_load),
    .load_val (mtime_load_val),
    .count    (mtime_val)
  );

  // mtime read returns the counter value before this cycle's increment.
  always_comb begin
    rd_data = '0;
    if (sel_msip)     rd_data = {63'd0, msip_q};
    if (sel_mtimecmp) rd_data = mtimecmp_q;
    if (sel_mtime)    rd_data = mtime_val;
  end

  always_comb begin
    msip_d = msip_q;
    if (do_write && sel_msip && req_wstrb[0]) msip_d = req_wdata[0];
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (do_write && sel_mtimecmp) mtimecmp_d = clint_merge(mtimecmp_q, req_wdata, req_wstrb);
  end

  assign mtip_d = (mtime_val >= mtimecmp_q);

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      CLINT_IDLE: begin
        if (req_valid) begin
          state_d     = CLINT_RESP;
          rsp_err_d   = !hit;
          rsp_rdata_d = (hit && !req_we) ? rd_data : 64'd0;
        end
      end
      CLINT_RESP: begin
        if (rsp_ready) state_d = CLINT_IDLE;
      end
      default: state_d = CLINT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLINT_IDLE;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == CLINT_IDLE);
  assign rsp_valid = (state_q == CLINT_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mtip      = mtip_q;
  assign msip      = msip_q;

endmodule
